// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared widths, NOP encoding and the fetch queue entry type.
package pipeline_pkg;
  localparam int PC_W = 9;
  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] NOP_INST = 32'h00000013;
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: 2-entry FIFO of fetch entries with push/pop/clear.
// Ports: clk, reset (async, active-low), push/din write the tail, pop drops the head,
// clear empties the queue (wins over push/pop), count = occupancy 0..2, head = entry 0.
import pipeline_pkg::*;
module fetch_fifo (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  fetch_entry_t din,
  output logic [1:0]   count,
  output fetch_entry_t head
);
  fetch_entry_t mem [2];
  logic pop_ok;
  logic [1:0] widx;
  assign pop_ok = pop && count != 2'd0;
  // Tail slot after this cycle's pop; entry 0 is always the head.
  assign widx = count - {1'b0, pop_ok};
  assign head = mem[0];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      count  <= '0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      if (pop_ok) mem[0] <= mem[1];
      if (push && !widx[1]) mem[widx[0]] <= din;
      count <= count + {1'b0, push && !widx[1]} - {1'b0, pop_ok};
    end
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: PC owner and instruction fetch front end with a 2-entry output queue.
// Ports: clk, reset (async, active-low); imem_req/imem_addr/imem_rdata to a 1-cycle
// synchronous instruction memory; redirect/redirect_pc from EX; id_valid/id_ready/
// id_inst/id_pc stream to decode (NOP and pc 0 while id_valid is low).
import pipeline_pkg::*;
module fetch_queue #(
  parameter int              PC_W     = pipeline_pkg::PC_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [INST_W-1:0] id_inst,
  output logic [PC_W-1:0]   id_pc
);
  logic [PC_W-1:0] pc, addr_q, tgt;
  logic inflight, drop, push, pop, issue;
  logic [1:0] count;
  logic [2:0] occ;
  fetch_entry_t head, din;
  assign tgt = {redirect_pc[PC_W-1:2], 2'b00};
  assign id_valid = count != 2'd0;
  assign pop = id_valid && id_ready && !redirect;
  // inflight marks that imem_rdata carries a response this cycle; a redirect
  // discards it along with everything already queued.
  assign drop = redirect && inflight;
  assign push = inflight && !drop;
  // Occupancy after this cycle counting the outstanding read; issue only if a slot stays free.
  assign occ = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
  assign issue = reset && (redirect || occ < 3'd2);
  assign imem_req = issue;
  assign imem_addr = redirect ? tgt : pc;
  assign din = '{inst: imem_rdata, pc: addr_q};
  assign id_inst = id_valid ? head.inst : NOP_INST;
  assign id_pc = id_valid ? head.pc : '0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pc       <= RESET_PC;
      addr_q   <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc     <= imem_addr + PC_W'(4);
        addr_q <= imem_addr;
      end
    end
  fetch_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .clear (redirect),
    .din   (din),
    .count (count),
    .head  (head)
  );
endmodule
